// File: rtl/accbuf_stream.sv
// Accumulator result FIFO with a run/drain tracker: buffers {data, addr, shotcnt}
// writes and streams them out first-word-fall-through over a valid/ready port.
`timescale 1ns/1ps
module accbuf_stream #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRWIDTH = 10,
  parameter int DEPTHLOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] data,
  input  logic [31:0]          shotcnt,
  input  logic                 lastshotdone,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic [ADDRWIDTH-1:0] m_addr,
  output logic [31:0]          m_shot,
  output logic                 m_last,
  output logic [DEPTHLOG2:0]   level,
  output logic [15:0]          ovf_cnt,
  output logic                 ovf,
  output logic                 drain_done,
  output logic                 busy
);

  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam logic [DEPTHLOG2:0] FULL_LEVEL = (DEPTHLOG2 + 1)'(DEPTH);
  localparam logic [DEPTHLOG2:0] ONE_LEVEL  = (DEPTHLOG2 + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [ADDRWIDTH-1:0] addr;
    logic [31:0]          shot;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               head;
  logic [DEPTHLOG2-1:0] wr_ptr;
  logic [DEPTHLOG2-1:0] rd_ptr;
  state_t               state;
  state_t               state_nxt;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign m_valid = (level != '0);
  assign full    = (level == FULL_LEVEL);
  assign pop     = m_valid & m_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push    = we & ~clear & (~full | pop);
  assign drop    = we & ~clear & ~push;

  assign head    = mem[rd_ptr];
  assign m_data  = head.data;
  assign m_addr  = head.addr;
  assign m_shot  = head.shot;

  assign busy    = (state != IDLE);
  assign m_last  = m_valid & (state == DRAIN) & (level == ONE_LEVEL) & ~we;

  // NOTE: storage has no reset; validity is carried entirely by level/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: data, addr: addr, shot: shotcnt};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clear) begin
      ovf_cnt <= '0;
      ovf     <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  // NOTE: next-state gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = RUN;
      RUN:     if (lastshotdone) state_nxt = DRAIN;
      DRAIN:   if (!push && (level == '0 || (pop && level == ONE_LEVEL))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_done <= (state == DRAIN) && (state_nxt == IDLE) && !clear;
    end
  end

endmodule

// File: tb/tb_accbuf_stream.sv
// Bench for accbuf_stream: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_accbuf_stream;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        we = 1'b0;
  logic [9:0]  addr = '0;
  logic [63:0] data = '0;
  logic [31:0] shotcnt = '0;
  logic        lastshotdone = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [63:0] m_data;
  logic [9:0]  m_addr;
  logic [31:0] m_shot;
  logic        m_last;
  logic [4:0]  level;
  logic [15:0] ovf_cnt;
  logic        ovf;
  logic        drain_done;
  logic        busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  accbuf_stream dut (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .addr(addr), .data(data),
    .shotcnt(shotcnt), .lastshotdone(lastshotdone), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_shot(m_shot), .m_last(m_last), .level(level),
    .ovf_cnt(ovf_cnt), .ovf(ovf), .drain_done(drain_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] d;
    logic [9:0]  a;
    logic [31:0] s;
  } ent_t;

  ent_t        mq[$];
  int          mst = 0;       // 0 idle, 1 run, 2 drain
  logic [15:0] m_ovfc = '0;
  logic        m_ovf = 1'b0;
  logic        m_dd = 1'b0;
  int          m_n;
  bit          m_pop;
  bit          m_acc;
  ent_t        m_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mst = 0; m_ovfc = '0; m_ovf = 1'b0; m_dd = 1'b0;
    end else begin
      m_n   = mq.size();
      m_pop = (m_n > 0) && m_ready;
      m_dd  = 1'b0;
      if (clear) begin
        mq.delete();
        mst = 0; m_ovfc = '0; m_ovf = 1'b0;
      end else begin
        m_acc = we && ((m_n < DEPTH) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          m_e.d = data; m_e.a = addr; m_e.s = shotcnt;
          mq.push_back(m_e);
        end else if (we) begin
          m_ovf = 1'b1;
          if (m_ovfc != 16'hFFFF) m_ovfc = m_ovfc + 16'd1;
        end
        case (mst)
          0: if (m_acc) mst = 1;
          1: if (lastshotdone) mst = 2;
          default: if (!m_acc && mq.size() == 0) begin mst = 0; m_dd = 1'b1; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", m_valid, 64'(mq.size() != 0));
      check("level", level, 64'(mq.size()));
      if (mq.size() != 0) begin
        check("m_data", m_data, mq[0].d);
        check("m_addr", m_addr, 64'(mq[0].a));
        check("m_shot", m_shot, 64'(mq[0].s));
      end
      check("ovf_cnt", ovf_cnt, 64'(m_ovfc));
      check("ovf", ovf, 64'(m_ovf));
      check("busy", busy, 64'(mst != 0));
      check("m_last", m_last, 64'(mq.size() == 1 && mst == 2 && !we));
      check("drain_done", drain_done, 64'(m_dd));
    end
  end

  // Beat recorder for the end-of-run scenario.
  bit          rec_en = 1'b0;
  logic [63:0] beat_d[$];
  logic        beat_l[$];
  always @(negedge clk) begin
    if (rec_en && m_valid && m_ready) begin
      beat_d.push_back(m_data);
      beat_l.push_back(m_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_drain_done", drain_done, 0);

    // Single write, one-cycle latency
    step();
    we = 1; addr = 10'd5; data = 64'h00000010_00000020; shotcnt = 32'd3; m_ready = 1;
    step();
    we = 0;
    @(negedge clk);
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 64'h00000010_00000020);
    check("single_addr", m_addr, 5);
    check("single_shot", m_shot, 3);
    step();
    @(negedge clk);
    check("single_gone", m_valid, 0);
    check("single_busy", busy, 1);

    // lastshotdone with an empty FIFO: DRAIN then straight back to IDLE
    step();
    lastshotdone = 1;
    step();
    lastshotdone = 0;
    @(negedge clk);
    check("empty_drain_busy", busy, 1);
    @(negedge clk);
    check("empty_drain_done", drain_done, 1);
    check("empty_drain_idle", busy, 0);

    // Overflow: 20 writes into a 16-deep FIFO
    m_ready = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      we = 1; data = 64'(i); addr = 10'(i); shotcnt = 32'(i);
    end
    step();
    we = 0;
    @(negedge clk);
    check("ovf_level", level, 16);
    check("ovf_count", ovf_cnt, 4);
    check("ovf_flag", ovf, 1);
    check("ovf_head", m_data, 0);
    check("model_level", 64'(mq.size()), 16);
    check("model_ovf_cnt", 64'(m_ovfc), 4);

    // Full plus simultaneous push/pop
    step();
    we = 1; data = 64'd100; addr = 10'd100; shotcnt = 32'd100; m_ready = 1;
    step();
    we = 0; m_ready = 0;
    @(negedge clk);
    check("full_rw_level", level, 16);
    check("full_rw_ovf_cnt", ovf_cnt, 4);
    check("full_rw_head", m_data, 1);

    step();
    m_ready = 1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("order", m_data, 64'(i));
    end
    @(negedge clk);
    check("order_last", m_data, 100);
    @(negedge clk);
    check("drained_level", level, 0);
    check("drained_ovf", ovf, 1);

    // Clear resets counters and state
    step();
    clear = 1;
    step();
    clear = 0;
    @(negedge clk);
    check("clr_ovf", ovf, 0);
    check("clr_ovf_cnt", ovf_cnt, 0);
    check("clr_busy", busy, 0);

    // End of run: 3 writes, lastshotdone with the third
    beat_d.delete(); beat_l.delete();
    rec_en = 1;
    step();
    m_ready = 1; we = 1; data = 64'hA; addr = 10'd1; shotcnt = 32'd1;
    step();
    data = 64'hB;
    step();
    data = 64'hC; lastshotdone = 1;
    step();
    we = 0; lastshotdone = 0;
    @(negedge clk);
    check("eor_last", m_last, 1);
    check("eor_last_data", m_data, 64'hC);
    check("eor_no_done_yet", drain_done, 0);
    step();
    @(negedge clk);
    check("eor_drain_done", drain_done, 1);
    check("eor_busy", busy, 0);
    rec_en = 0;
    check("eor_beats", 64'(beat_d.size()), 3);
    if (beat_d.size() == 3) begin
      check("eor_b0", beat_d[0], 64'hA);
      check("eor_b1", beat_d[1], 64'hB);
      check("eor_b2", beat_d[2], 64'hC);
      check("eor_l0", beat_l[0], 0);
      check("eor_l1", beat_l[1], 0);
      check("eor_l2", beat_l[2], 1);
    end
    @(negedge clk);
    check("eor_done_once", drain_done, 0);

    // Clear mid-run together with a write
    step();
    m_ready = 0;
    for (int i = 0; i < 7; i++) begin
      we = 1; data = 64'(200 + i); addr = 10'(i); shotcnt = 32'(i);
      step();
    end
    clear = 1;
    @(negedge clk);
    check("cmr_level_before", level, 7);
    check("cmr_busy_before", busy, 1);
    step();
    clear = 0; we = 0;
    @(negedge clk);
    check("cmr_level", level, 0);
    check("cmr_valid", m_valid, 0);
    check("cmr_ovf_cnt", ovf_cnt, 0);
    check("cmr_busy", busy, 0);
    check("cmr_no_done", drain_done, 0);

    // Async reset mid-beat
    step();
    for (int i = 0; i < 3; i++) begin
      we = 1; data = 64'(300 + i); addr = 10'(i); shotcnt = 32'(i);
      step();
    end
    we = 0; m_ready = 1;
    step();
    reset = 0;
    #2;
    check("arst_valid", m_valid, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1;
    we = 1; addr = 10'd7; data = 64'h0000DEAD_0000BEEF; shotcnt = 32'd9;
    step();
    we = 0;
    @(negedge clk);
    check("arst_new_valid", m_valid, 1);
    check("arst_new_data", m_data, 64'h0000DEAD_0000BEEF);
    check("arst_new_addr", m_addr, 7);
    check("arst_new_shot", m_shot, 9);
    check("arst_new_level", level, 1);

    // Randomized traffic in phases with varying write/ready pressure
    for (int p = 0; p < 12; p++) begin
      int we_pct;
      int rdy_pct;
      we_pct  = $urandom_range(20, 95);
      rdy_pct = $urandom_range(5, 95);
      for (int c = 0; c < 200; c++) begin
        step();
        we           = ($urandom_range(0, 99) < we_pct);
        m_ready      = ($urandom_range(0, 99) < rdy_pct);
        lastshotdone = ($urandom_range(0, 47) == 0);
        clear        = ($urandom_range(0, 299) == 0);
        data         = {$urandom, $urandom};
        addr         = 10'($urandom);
        shotcnt      = $urandom;
      end
    end
    step();
    we = 0; m_ready = 1; lastshotdone = 0; clear = 0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accbuf_stream.md
ACCBUF_STREAM -- requirements
Module: accbuf_stream

Interface
REQ-001 Parameter DATAWIDTH, default 64, accumulator word width: accx in [63:32], accy in [31:0].
REQ-002 Parameter ADDRWIDTH, default 10, accumulator buffer address width.
REQ-003 Parameter DEPTHLOG2, default 4, FIFO depth of 2^DEPTHLOG2 entries.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous flush; driven from the per-channel resetacc.
REQ-007 we  input  1  accumulator write strobe, one result per cycle when high.
REQ-008 addr  input  ADDRWIDTH  accumulator buffer write address accompanying we.
REQ-009 data  input  DATAWIDTH  accumulator result accompanying we.
REQ-010 shotcnt  input  32  current shot index, sampled with we.
REQ-011 lastshotdone  input  1  one-cycle pulse marking completion of the final shot.
REQ-012 m_valid  output  1  output entry available.
REQ-013 m_ready  input  1  consumer accepts the entry; a beat transfers when m_valid and m_ready are both high.
REQ-014 m_data  output  DATAWIDTH  captured data.
REQ-015 m_addr  output  ADDRWIDTH  captured addr.
REQ-016 m_shot  output  32  captured shotcnt.
REQ-017 m_last  output  1  marks the final beat of a run.
REQ-018 level  output  DEPTHLOG2+1  current FIFO occupancy.
REQ-019 ovf_cnt  output  16  count of dropped writes, saturating.
REQ-020 ovf  output  1  sticky overflow flag.
REQ-021 drain_done  output  1  one-cycle pulse when a run has fully drained.
REQ-022 busy  output  1  high whenever the state is not IDLE.

Function
REQ-023 Push condition: we high, clear low, and either level < 2^DEPTHLOG2 or a beat transfers in the same cycle; the entry stored is {data, addr, shotcnt}.
REQ-024 Read mode is first-word-fall-through: m_valid = (level != 0); m_data, m_addr and m_shot reflect the oldest entry.
REQ-025 Latency: we accepted in cycle N -> m_valid high in cycle N+1 when the FIFO was empty.
REQ-026 Full-cycle write: a push and pop in the same cycle at level = 2^DEPTHLOG2 is accepted and level is unchanged.
REQ-027 Same-cycle push and pop at level 0 is impossible because m_valid is low; the push lands and level becomes 1.
REQ-028 Overflow: we high with push refused -> entry dropped; ovf_cnt += 1, saturating at 16'hFFFF; ovf set until reset or clear.
REQ-029 Entries are never reordered or duplicated; read and write pointers wrap modulo 2^DEPTHLOG2.
REQ-030 State machine, states IDLE, RUN, DRAIN:
  - IDLE -> RUN on an accepted push.
  - RUN -> DRAIN on lastshotdone.
  - DRAIN -> IDLE in the cycle a beat transfers at level = 1 with no push in that cycle, or immediately if level = 0 with no push.
REQ-031 lastshotdone in IDLE is ignored.
REQ-032 lastshotdone coinciding with a push in IDLE -> RUN only; that lastshotdone is lost.
REQ-033 Writes arriving in DRAIN are pushed normally and extend the drain.
REQ-034 m_last = m_valid & (state == DRAIN) & (level == 1) & ~we.
REQ-035 drain_done pulses for exactly one cycle on the DRAIN -> IDLE transition.
REQ-036 Priority: clear has priority over every other input:
  - next cycle: level 0, both pointers 0, state IDLE, ovf_cnt 0, ovf 0;
  - a we in the clear cycle is discarded and not counted;
  - drain_done is not pulsed.
REQ-037 m_ready while m_valid is low has no effect.

Reset
REQ-038 While reset is low, asynchronously force:
  - m_valid 0, m_last 0, level 0, ovf_cnt 0, ovf 0, drain_done 0, busy 0;
  - state IDLE, pointers 0.
REQ-039 FIFO storage contents are not reset; m_data, m_addr and m_shot are don't-care while m_valid is 0.
REQ-040 Reset deasserting mid-run restarts cleanly in IDLE; pre-reset entries are never emitted.

Verification
REQ-041 Single write: we with addr=5, data=64'h00000010_00000020, shotcnt=3, m_ready=1 -> m_valid high for one cycle, next cycle, with matching fields; busy 1 afterward.
REQ-042 Overflow (DEPTHLOG2=4): m_ready=0, 20 consecutive writes -> level=16, ovf_cnt=4, ovf=1; then m_ready=1 -> exactly the first 16 entries emerge in order.
REQ-043 Full plus simultaneous: at level 16, we and m_ready in the same cycle -> write accepted, level stays 16, ovf_cnt unchanged.
REQ-044 End of run: 3 writes, lastshotdone, m_ready=1 -> 3 beats with m_last only on the third; drain_done one cycle after the third beat transfers; busy 0.
REQ-045 Clear mid-run: level 7 and state RUN, clear together with we -> next cycle level 0, m_valid 0, ovf_cnt 0, state IDLE, no drain_done.
REQ-046 Async reset: reset low mid-beat, between clock edges -> m_valid and level 0 immediately; after release the first write emerges with its own fields only.
